traffic_generator: RTL

//  Per-PE packet source on a router Local input port; the upstream twin of the collector.

---
 rtl/noc_pkg.sv | 39 +++
 rtl/traffic_generator_if.sv | 12 +
 rtl/tg_lfsr16.sv | 33 +++
 rtl/traffic_generator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, generator FSM states and helpers.
// The collector uses the same layout to pull fields back out of a flit.
package noc_pkg;

  localparam int FLIT_W = 32;
  localparam int TS_W   = 10;
  localparam int NODE_W = 6;
  localparam int PID_W  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP      = 2'd1,
    REQ      = 2'd2,
    WAIT_GNT = 2'd3
  } tg_state_e;

  // Flit layout: {timestamp[9:0], dest[5:0], packet_id[9:0], sender[5:0]}
  function automatic logic [FLIT_W-1:0] build_flit(input logic [TS_W-1:0]   ts,
                                                   input logic [NODE_W-1:0] dest,
                                                   input logic [PID_W-1:0]  pid,
                                                   input logic [NODE_W-1:0] sender);
    return {ts, dest, pid, sender};
  endfunction

  // Random destination inside the mesh, nudged in x when it lands on ourselves.
  function automatic logic [NODE_W-1:0] lfsr_dest(input logic [15:0]       lfsr,
                                                  input logic [NODE_W-1:0] self_id,
                                                  input logic [2:0]        mask);
    logic [2:0] x;
    logic [2:0] y;
    x = lfsr[2:0] & mask;
    y = lfsr[5:3] & mask;
    if ({x, y} == self_id) begin
      x = (x + 3'd1) & mask;
    end
    return {x, y};
  endfunction

endpackage

// File: rtl/traffic_generator_if.sv
// Local-port injection handshake between a traffic generator and its router.
interface traffic_generator_if #(
  parameter int DW = 32
);
  logic [DW-1:0] PacketOut;
  logic          ReqDnStr;
  logic          GntDnStr;
  logic          DnStrFull;

  modport master (output PacketOut, output ReqDnStr, input GntDnStr, input DnStrFull);
  modport slave  (input PacketOut, input ReqDnStr, output GntDnStr, output DnStrFull);
endinterface

// File: rtl/tg_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stepped on demand, sync active-low reset to seed.
module tg_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/traffic_generator.sv
// Per-PE packet source: builds one-flit packets and injects them via Req/Gnt/Full.
// Define TG_LFSR_DEST_EN for LFSR-random destinations; otherwise DEST_ID is used.
module traffic_generator
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter int         dataWidth   = 32,
  parameter int         dim         = 4,
  parameter logic [5:0] DEST_ID     = 6'b000_001,
  parameter int         GAP_CYCLES  = 8,
  parameter int         NUM_PACKETS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  traffic_generator_if.master tg,
  output logic [15:0]         SentCount,
  output logic                done
);

  localparam logic [2:0]  DIM_MASK = 3'(dim - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  tg_state_e            state_q, state_d;
  logic [15:0]          gap_q, gap_d;
  logic [PID_W-1:0]     pid_q, pid_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [15:0]          sent_q, sent_d;
  logic                 done_q, done_d;
  logic                 req_q, req_d;
  logic [dataWidth-1:0] pkt_q, pkt_d;
  logic                 load_pkt;
  logic                 last_pkt;
  logic [NODE_W-1:0]    dest_w;

`ifdef TG_LFSR_DEST_EN
  logic [15:0] lfsr_w;

  tg_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (load_pkt),
    .lfsr  (lfsr_w)
  );

  assign dest_w = lfsr_dest(lfsr_w, routerID, DIM_MASK);
`else
  // Coordinates are confined to the mesh; a legal DEST_ID passes through untouched.
  assign dest_w = DEST_ID & {DIM_MASK, DIM_MASK};
`endif

  assign last_pkt = (NUM_PACKETS != 0) && (({16'd0, sent_q} + 32'd1) == 32'(NUM_PACKETS));

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pid_d    = pid_q;
    cycle_d  = cycle_q + 32'd1;
    sent_d   = sent_q;
    done_d   = done_q;
    req_d    = req_q;
    pkt_d    = pkt_q;
    load_pkt = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && !done_q) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == 16'd0) begin
          state_d = REQ;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      REQ: begin
        if (!tg.DnStrFull && !tg.GntDnStr && enable) begin
          load_pkt = 1'b1;
          req_d    = 1'b1;
          state_d  = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // Request is never withdrawn here: the router owns arbitration once we ask.
        if (tg.GntDnStr) begin
          req_d = 1'b0;
          pid_d = pid_q + 10'd1;
          if (sent_q != 16'hFFFF) begin
            sent_d = sent_q + 16'd1;
          end
          if (last_pkt) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_pkt) begin
      pkt_d = dataWidth'(build_flit(cycle_q[TS_W-1:0], dest_w, pid_q, routerID));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pid_q   <= '0;
      cycle_q <= '0;
      sent_q  <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pid_q   <= pid_d;
      cycle_q <= cycle_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
      req_q   <= req_d;
      pkt_q   <= pkt_d;
    end
  end

  // Only the low timestamp bits travel in the flit; the rest just keep the counter 32-bit.
  logic unused_cycle_hi;
  assign unused_cycle_hi = ^cycle_q[31:TS_W];

  assign tg.PacketOut = pkt_q;
  assign tg.ReqDnStr  = req_q;
  assign SentCount    = sent_q;
  assign done         = done_q;

endmodule
